// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the fetch PC, issues word reads to a 1-cycle-latency
// instruction bram, buffers the returned words with their PCs in a small prefetch FIFO,
// and presents them to decode over a valid/ready handshake. Branch redirects flush
// everything buffered or in flight.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_enable,
  output logic                  bram_enable,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [31:0]           bram_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [31:0]           inst_pc
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q;
  logic [31:0]           fetch_pc_q;
  logic [31:0]           issue_pc_q;
  logic                  inflight_q;
  logic [CntW-1:0]       occ_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [31:0]           data_mem_q [FIFO_DEPTH];
  logic [31:0]           pc_mem_q   [FIFO_DEPTH];

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CntW:0]         credit;

  // Issue/credit logic and FIFO head presentation
  always_comb begin
    pop    = inst_valid & inst_ready;
    // Data returning during a redirect belongs to the killed read.
    push   = inflight_q & ~redirect_valid;
    // Entries that will occupy the FIFO once the outstanding read lands; pop never
    // exceeds occ, so this cannot underflow.
    credit = {1'b0, occ_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    issue  = (state_q == StRun) & ~redirect_valid & (credit < (CntW + 1)'(FIFO_DEPTH));

    bram_enable = issue;
    bram_addr   = fetch_pc_q[ADDR_WIDTH+1:2];

    inst_valid = (occ_q != '0);
    inst_data  = data_mem_q[rd_ptr_q];
    inst_pc    = pc_mem_q[rd_ptr_q];
  end

  // Fetch FSM: run/idle state, fetch PC, in-flight tracking and issued-PC capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle:  if (fetch_enable) state_q <= StRun;
        StRun:   if (!fetch_enable) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // issue is already suppressed by a redirect, so this also kills nothing new.
      inflight_q <= issue;

      if (redirect_valid) begin
        fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        issue_pc_q <= fetch_pc_q;
      end
    end
  end

  // Prefetch FIFO: push returned words, pop on handshake, flush on redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // A same-cycle pop is simply consumed; the whole buffer is dropped.
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= bram_data;
        pc_mem_q[wr_ptr_q]   <= issue_pc_q;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      occ_q <= occ_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule
